// File: rtl/poly_voice_mixer.sv
// poly_voice_mixer: allocates incoming notes to NUM_VOICES external note
// players and tracks each voice's remaining duration in beats. It also mixes
// the samples of the active voices into one output sample that is normalised
// by the number of active voices.
// Optional feature macro: POLY_VOICE_STEAL_EN. When it is defined and every
// voice is busy, the voice with the least remaining time is stolen, and the
// voice_stolen port is present.
module poly_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 16,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic                           beat,
    input  logic [NOTE_W-1:0]              note_in,
    input  logic [DUR_W-1:0]               dur_in,
    input  logic                           note_valid,
    output logic                           note_ready,
    output logic [NUM_VOICES-1:0]          voice_load,
    output logic [NOTE_W-1:0]              voice_note,
    output logic [DUR_W-1:0]               voice_dur,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic [3:0]                     active_count,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic                           samples_valid,
    output logic [SAMPLE_W-1:0]            sample_out,
    output logic                           sample_valid,
`ifdef POLY_VOICE_STEAL_EN
    output logic                           voice_stolen,
`endif
    output logic                           all_idle
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    // Three guard bits hold the sum of up to eight full-scale voices.
    localparam int SUM_W = SAMPLE_W + 3;

    // Count of set bits in the voice mask.
    function automatic logic [3:0] popcount(input logic [NUM_VOICES-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            c = c + {3'b000, v[k]};
        end
        return c;
    endfunction

    // Normalising shift for a given active-voice count.
    function automatic logic [1:0] mix_shift(input logic [3:0] cnt);
        logic [1:0] s;
        case (cnt)
            4'd0, 4'd1: s = 2'd0;
            4'd2:       s = 2'd1;
            4'd3, 4'd4: s = 2'd2;
            default:    s = 2'd3;
        endcase
        return s;
    endfunction

    logic [NUM_VOICES-1:0]            active_q, active_d;
    logic [NUM_VOICES-1:0][DUR_W-1:0] cnt_q, cnt_d;
    logic [NUM_VOICES-1:0]            load_q, load_d;
    logic [NOTE_W-1:0]                note_q, note_d;
    logic [DUR_W-1:0]                 dur_q, dur_d;
    logic [3:0]                       count_q, count_d;
    logic                             idle_q, idle_d;
    logic [SAMPLE_W-1:0]              sample_q, sample_d;
    logic                             svalid_q, svalid_d;
`ifdef POLY_VOICE_STEAL_EN
    logic                             stolen_q, stolen_d;
    logic [IDX_W-1:0]                 victim_idx_s;
    logic [DUR_W-1:0]                 victim_min_s;
`endif

    logic                             free_found_s;
    logic [IDX_W-1:0]                 free_idx_s;
    logic [IDX_W-1:0]                 alloc_idx_s;
    logic                             accept_s;
    logic                             load_en_s;
    logic [SUM_W-1:0]                 sum_s;
    logic signed [SUM_W-1:0]          shifted_s;
    logic [SAMPLE_W-1:0]              mix_s;
    logic [SAMPLE_W-1:0]              smp_s;

    // Find the lowest-index free voice. The loop walks downwards so that the
    // lowest index is the last one written.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = i[IDX_W-1:0];
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

`ifdef POLY_VOICE_STEAL_EN
    // Choose the steal victim: smallest remaining count, ties to lowest index.
    always_comb begin
        victim_idx_s = '0;
        victim_min_s = cnt_q[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (cnt_q[i] < victim_min_s) begin
                victim_min_s = cnt_q[i];
                victim_idx_s = i[IDX_W-1:0];
            end else begin
                victim_min_s = victim_min_s;
            end
        end
    end

    assign note_ready  = 1'b1;
    assign alloc_idx_s = free_found_s ? free_idx_s : victim_idx_s;
`else
    assign note_ready  = free_found_s;
    assign alloc_idx_s = free_idx_s;
`endif

    assign accept_s  = note_valid & note_ready;
    // A zero-length request is accepted but never occupies a voice.
    assign load_en_s = accept_s & (dur_in != {DUR_W{1'b0}});

    // Voice state next-state: beat countdown first, then a new load overrides
    // the chosen voice so that it keeps dur_in without a decrement.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        load_d   = '0;
        note_d   = note_q;
        dur_d    = dur_q;
`ifdef POLY_VOICE_STEAL_EN
        stolen_d = 1'b0;
`endif
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (beat && play && active_q[i]) begin
                cnt_d[i] = cnt_q[i] - DUR_W'(1);
                if (cnt_q[i] == DUR_W'(1)) begin
                    active_d[i] = 1'b0;
                end else begin
                    active_d[i] = active_q[i];
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
        if (load_en_s) begin
            cnt_d[alloc_idx_s]    = dur_in;
            active_d[alloc_idx_s] = 1'b1;
            load_d[alloc_idx_s]   = 1'b1;
            note_d                = note_in;
            dur_d                 = dur_in;
`ifdef POLY_VOICE_STEAL_EN
            stolen_d              = ~free_found_s;
`endif
        end else begin
            note_d = note_q;
        end
        count_d = popcount(active_d);
        idle_d  = (active_d == '0) && (load_d == '0);
    end

    // Mixer: sign-extended sum of the active voices, then an arithmetic shift
    // by the count-dependent amount. The mask is the registered voice state.
    always_comb begin
        sum_s = '0;
        smp_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            smp_s = voice_samples[i*SAMPLE_W +: SAMPLE_W];
            if (active_q[i]) begin
                sum_s = sum_s + {{3{smp_s[SAMPLE_W-1]}}, smp_s};
            end else begin
                sum_s = sum_s;
            end
        end
        shifted_s = $signed(sum_s) >>> mix_shift(count_q);
        mix_s     = shifted_s[SAMPLE_W-1:0];
        if (samples_valid) begin
            sample_d = mix_s;
        end else begin
            sample_d = sample_q;
        end
        svalid_d = samples_valid;
    end

    // State and output registers. Reset frees every voice and cancels any
    // load pulse that is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= '0;
            cnt_q    <= '0;
            load_q   <= '0;
            note_q   <= '0;
            dur_q    <= '0;
            count_q  <= 4'd0;
            idle_q   <= 1'b1;
            sample_q <= '0;
            svalid_q <= 1'b0;
`ifdef POLY_VOICE_STEAL_EN
            stolen_q <= 1'b0;
`endif
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            note_q   <= note_d;
            dur_q    <= dur_d;
            count_q  <= count_d;
            idle_q   <= idle_d;
            sample_q <= sample_d;
            svalid_q <= svalid_d;
`ifdef POLY_VOICE_STEAL_EN
            stolen_q <= stolen_d;
`endif
        end
    end

    assign voice_active = active_q;
    assign voice_load   = load_q;
    assign voice_note   = note_q;
    assign voice_dur    = dur_q;
    assign active_count = count_q;
    assign all_idle     = idle_q;
    assign sample_out   = sample_q;
    assign sample_valid = svalid_q;
`ifdef POLY_VOICE_STEAL_EN
    assign voice_stolen = stolen_q;
`endif

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Directed bench for poly_voice_mixer (4 voices, 16-bit samples).
module tb_poly_voice_mixer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        play = 1'b1;
    logic        beat = 1'b0;
    logic [5:0]  note_in = 6'd0;
    logic [5:0]  dur_in = 6'd0;
    logic        note_valid = 1'b0;
    logic        note_ready;
    logic [3:0]  voice_load;
    logic [5:0]  voice_note;
    logic [5:0]  voice_dur;
    logic [3:0]  voice_active;
    logic [3:0]  active_count;
    logic [63:0] voice_samples = 64'd0;
    logic        samples_valid = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        all_idle;
`ifdef POLY_VOICE_STEAL_EN
    logic        voice_stolen;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          nv;
        logic [63:0] smp;
        logic [15:0] exp;
    } mix_vec_t;

    mix_vec_t vecs[10];

    poly_voice_mixer dut (
        .clk(clk), .reset(reset), .play(play), .beat(beat),
        .note_in(note_in), .dur_in(dur_in), .note_valid(note_valid),
        .note_ready(note_ready), .voice_load(voice_load),
        .voice_note(voice_note), .voice_dur(voice_dur),
        .voice_active(voice_active), .active_count(active_count),
        .voice_samples(voice_samples), .samples_valid(samples_valid),
        .sample_out(sample_out), .sample_valid(sample_valid),
`ifdef POLY_VOICE_STEAL_EN
        .voice_stolen(voice_stolen),
`endif
        .all_idle(all_idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_note(input logic [5:0] n, input logic [5:0] d);
        int w;
        note_in = n;
        dur_in = d;
        note_valid = 1'b1;
        w = 0;
        while (!note_ready && w < 50) begin
            tick();
            w++;
        end
        check("ready_wait", (w < 50) ? 32'd1 : 32'd0, 32'd1);
        tick();
        note_valid = 1'b0;
    endtask

    task automatic do_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        vecs[0] = '{3, {16'h0000, 16'hFDA8, 16'h0BB8, 16'h0BB8}, 16'd1350};
        vecs[1] = '{3, {16'h3039, 16'hFDA8, 16'h0BB8, 16'h0BB8}, 16'd1350};
        vecs[2] = '{3, {16'h0000, 16'hFFFC, 16'hFFFC, 16'hFFFC}, 16'hFFFD};
        vecs[3] = '{3, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 16'hFFFF};
        vecs[4] = '{3, {16'h0000, 16'h0001, 16'h0001, 16'h0001}, 16'h0000};
        vecs[5] = '{1, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h7FFF};
        vecs[6] = '{2, {16'h1234, 16'h1234, 16'hFFCE, 16'h0064}, 16'd25};
        vecs[7] = '{4, {16'h8000, 16'h8000, 16'h8000, 16'h8000}, 16'h8000};
        vecs[8] = '{4, {16'hFFF9, 16'h0003, 16'h0002, 16'h0001}, 16'hFFFF};
        vecs[9] = '{4, {16'h0007, 16'h0007, 16'h0007, 16'h0007}, 16'h0007};

        // Reset state
        #12;
        check("rst_active", {28'd0, voice_active}, 32'd0);
        check("rst_load", {28'd0, voice_load}, 32'd0);
        check("rst_sample", {16'd0, sample_out}, 32'd0);
        check("rst_svalid", {31'd0, sample_valid}, 32'd0);
        reset = 1'b1;
        tick();
        check("rst_ready", {31'd0, note_ready}, 32'd1);
        check("rst_idle", {31'd0, all_idle}, 32'd1);
        check("rst_count", {28'd0, active_count}, 32'd0);

        // Allocation and expiry
        send_note(6'd10, 6'd3);
        check("alloc0_load", {28'd0, voice_load}, 32'h1);
        check("alloc0_note", {26'd0, voice_note}, 32'd10);
        check("alloc0_dur", {26'd0, voice_dur}, 32'd3);
        check("alloc0_idle", {31'd0, all_idle}, 32'd0);
        send_note(6'd20, 6'd1);
        check("alloc1_load", {28'd0, voice_load}, 32'h2);
        check("alloc1_note", {26'd0, voice_note}, 32'd20);
        check("alloc1_active", {28'd0, voice_active}, 32'h3);
        check("alloc1_count", {28'd0, active_count}, 32'd2);
        do_beat();
        check("beat1_active", {28'd0, voice_active}, 32'h1);
        check("beat1_load", {28'd0, voice_load}, 32'h0);
        do_beat();
        check("beat2_active", {28'd0, voice_active}, 32'h1);
        do_beat();
        check("beat3_active", {28'd0, voice_active}, 32'h0);
        check("beat3_idle", {31'd0, all_idle}, 32'd1);

        // Zero duration is dropped
        send_note(6'd5, 6'd0);
        check("dur0_load", {28'd0, voice_load}, 32'h0);
        check("dur0_active", {28'd0, voice_active}, 32'h0);
        check("dur0_idle", {31'd0, all_idle}, 32'd1);

        // play low freezes counters
        send_note(6'd7, 6'd2);
        play = 1'b0;
        for (int b = 0; b < 5; b++) do_beat();
        check("pause_active", {28'd0, voice_active}, 32'h1);
        play = 1'b1;
        do_beat();
        check("resume1_active", {28'd0, voice_active}, 32'h1);
        do_beat();
        check("resume2_active", {28'd0, voice_active}, 32'h0);

        // Fill all voices with remaining 5,2,2,7
        send_note(6'd1, 6'd5);
        send_note(6'd2, 6'd2);
        send_note(6'd3, 6'd2);
        send_note(6'd4, 6'd7);
        check("full_active", {28'd0, voice_active}, 32'hF);
        note_in = 6'd33;
        dur_in = 6'd9;
        note_valid = 1'b1;
`ifdef POLY_VOICE_STEAL_EN
        check("steal_ready", {31'd0, note_ready}, 32'd1);
        tick();
        note_valid = 1'b0;
        check("steal_load", {28'd0, voice_load}, 32'h2);
        check("steal_flag", {31'd0, voice_stolen}, 32'd1);
        check("steal_dur", {26'd0, voice_dur}, 32'd9);
        check("steal_cnt", {26'd0, dut.cnt_q[1]}, 32'd9);
        tick();
        check("steal_flag_off", {31'd0, voice_stolen}, 32'd0);
`else
        check("full_ready", {31'd0, note_ready}, 32'd0);
        tick();
        check("full_hold_load", {28'd0, voice_load}, 32'h0);
        do_beat();
        check("full_beat1_active", {28'd0, voice_active}, 32'hF);
        check("full_beat1_ready", {31'd0, note_ready}, 32'd0);
        do_beat();
        check("full_beat2_active", {28'd0, voice_active}, 32'h9);
        check("full_beat2_load", {28'd0, voice_load}, 32'h0);
        check("full_beat2_ready", {31'd0, note_ready}, 32'd1);
        tick();
        note_valid = 1'b0;
        check("full_accept_load", {28'd0, voice_load}, 32'h2);
        check("full_accept_note", {26'd0, voice_note}, 32'd33);
        check("full_accept_active", {28'd0, voice_active}, 32'hB);
`endif

        // Mixing table
        for (int v = 0; v < 10; v++) begin
            if (v == 0 || vecs[v].nv != vecs[v-1].nv) begin
                do_reset();
                for (int k = 0; k < vecs[v].nv; k++) send_note(6'(k + 1), 6'd50);
                tick();
                check("mix_count", {28'd0, active_count}, 32'(vecs[v].nv));
            end
            voice_samples = vecs[v].smp;
            samples_valid = 1'b1;
            check("mix_pre_svalid", {31'd0, sample_valid}, 32'd0);
            tick();
            samples_valid = 1'b0;
            check("mix_svalid", {31'd0, sample_valid}, 32'd1);
            check($sformatf("mix_out_%0d", v), {16'd0, sample_out}, {16'd0, vecs[v].exp});
            tick();
            check("mix_svalid_pulse", {31'd0, sample_valid}, 32'd0);
        end

        // Reset mid-operation, four voices active and sample_out nonzero
        reset = 1'b0;
        #2;
        check("midrst_active", {28'd0, voice_active}, 32'h0);
        check("midrst_sample", {16'd0, sample_out}, 32'd0);
        reset = 1'b1;
        tick();
        check("midrst_ready", {31'd0, note_ready}, 32'd1);
        check("midrst_idle", {31'd0, all_idle}, 32'd1);

        // Reset cancels an in-flight load pulse
        send_note(6'd9, 6'd4);
        check("inflight_load", {28'd0, voice_load}, 32'h1);
        reset = 1'b0;
        #2;
        check("inflight_cancel", {28'd0, voice_load}, 32'h0);
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
